// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the 64-bit RISC-V datapath (ld, sd, R-type, beq, bne).
// A single state register walks FETCH/DECODE/EXEC/MEM/WB and the control strobes
// are decoded from that state and the latched instruction class.
// A wait counter bounds every memory handshake. Illegal opcodes and memory
// timeouts park the core in HALT until reset.
module multicycle_control #(
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_src,
   output logic [1:0] imm_sel,
   output logic       alu_src,
   output logic [1:0] alu_op,
   output logic       mem_req,
   output logic       mem_we,
   output logic       reg_write,
   output logic       mem_to_reg,
   output logic       halted,
   output logic       illegal,
   output logic       timeout
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   typedef enum logic [1:0] {C_LD, C_SD, C_R, C_BR} class_t;

   state_t            state;
   class_t            cls;
   logic              is_bne;
   logic [CNT_W-1:0]  wait_cnt;
   logic              illegal_q;
   logic              timeout_q;

   class_t            dec_cls;
   logic              dec_ok;
   logic              wait_last;
   logic              taken;

   // Immediate format selected by each instruction class (R-type has none).
   function automatic logic [1:0] imm_for(input class_t c);
      case (c)
         C_SD:    return 2'b01;
         C_BR:    return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   // Classify the instruction currently held in the instruction register.
   always_comb begin
      dec_cls = C_R;
      dec_ok  = 1'b1;
      case (opcode)
         7'b0000011: dec_cls = C_LD;
         7'b0100011: dec_cls = C_SD;
         7'b0110011: dec_cls = C_R;
         7'b1100011: begin
            dec_cls = C_BR;
            dec_ok  = (funct3[2:1] == 2'b00);
         end
         default:    dec_ok = 1'b0;
      endcase
   end

   assign wait_last = (wait_cnt == CNT_W'(TIMEOUT - 1));
   assign taken     = is_bne ? ~zero : zero;

   // Sequencer: state, latched class, handshake wait counter and sticky halt causes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         cls       <= C_LD;
         is_bne    <= 1'b0;
         wait_cnt  <= '0;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               state    <= S_FETCH;
               wait_cnt <= '0;
            end
            S_FETCH: begin
               if (mem_ready) begin
                  state    <= S_DECODE;
                  wait_cnt <= '0;
               end else if (wait_last) begin
                  state     <= S_HALT;
                  timeout_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_DECODE: begin
               if (dec_ok) begin
                  cls    <= dec_cls;
                  is_bne <= funct3[0];
                  state  <= S_EXEC;
               end else begin
                  state     <= S_HALT;
                  illegal_q <= 1'b1;
               end
            end
            S_EXEC: begin
               wait_cnt <= '0;
               case (cls)
                  C_LD, C_SD: state <= S_MEM;
                  C_R:        state <= S_WB;
                  default:    state <= S_FETCH;
               endcase
            end
            S_MEM: begin
               if (mem_ready) begin
                  state    <= (cls == C_LD) ? S_WB : S_FETCH;
                  wait_cnt <= '0;
               end else if (wait_last) begin
                  state     <= S_HALT;
                  timeout_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_WB: begin
               state    <= S_FETCH;
               wait_cnt <= '0;
            end
            S_HALT:  state <= S_HALT;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Moore control decode; only the FETCH write strobes follow mem_ready directly.
   always_comb begin
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      imm_sel    = 2'b00;
      alu_src    = 1'b0;
      alu_op     = 2'b00;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      halted     = (state == S_HALT);
      illegal    = illegal_q;
      timeout    = timeout_q;
      case (state)
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
            end
         end
         S_DECODE: imm_sel = imm_for(dec_cls);
         S_EXEC: begin
            imm_sel = imm_for(cls);
            case (cls)
               C_LD, C_SD: begin
                  alu_src = 1'b1;
                  alu_op  = 2'b00;
               end
               C_R: alu_op = 2'b10;
               default: begin
                  alu_op = 2'b01;
                  if (taken) begin
                     pc_write = 1'b1;
                     pc_src   = 1'b1;
                  end
               end
            endcase
         end
         S_MEM: begin
            imm_sel = imm_for(cls);
            mem_req = 1'b1;
            mem_we  = (cls == C_SD);
         end
         S_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = (cls == C_LD);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control. Each instruction is expanded from its
// class, memory wait schedule and branch outcome into the expected per-cycle
// control trace. That trace is queued as the inputs are driven, and a monitor
// pops and compares one entry per cycle in the middle of the clock period.
module tb_multicycle_control;

   localparam int TO = 16;

   typedef struct packed {
      logic       ir_write;
      logic       pc_write;
      logic       pc_src;
      logic [1:0] imm_sel;
      logic       alu_src;
      logic [1:0] alu_op;
      logic       mem_req;
      logic       mem_we;
      logic       reg_write;
      logic       mem_to_reg;
      logic       halted;
      logic       illegal;
      logic       timeout;
   } outv_t;

   logic       clk;
   logic       reset;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       zero;
   logic       mem_ready;
   logic       ir_write, pc_write, pc_src, alu_src, mem_req, mem_we;
   logic       reg_write, mem_to_reg, halted, illegal, timeout;
   logic [1:0] imm_sel, alu_op;

   logic [6:0] cur_op;
   logic [2:0] cur_f3;

   outv_t exp_q[$];
   outv_t mask_q[$];
   string name_q[$];
   int    tests = 0;
   int    fails = 0;

   multicycle_control #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .zero(zero),
      .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
      .imm_sel(imm_sel), .alu_src(alu_src), .alu_op(alu_op), .mem_req(mem_req),
      .mem_we(mem_we), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
      .halted(halted), .illegal(illegal), .timeout(timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // Strobes and status flags are always defined; other fields are added per cycle.
   function automatic outv_t bm();
      outv_t m;
      m           = '0;
      m.ir_write  = 1'b1;
      m.pc_write  = 1'b1;
      m.mem_req   = 1'b1;
      m.reg_write = 1'b1;
      m.halted    = 1'b1;
      m.illegal   = 1'b1;
      m.timeout   = 1'b1;
      return m;
   endfunction

   function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3);
      return (op == 7'b0000011) || (op == 7'b0100011) || (op == 7'b0110011) ||
             ((op == 7'b1100011) && (f3 == 3'b000 || f3 == 3'b001));
   endfunction

   // One clock period: drive inputs just after the edge, queue what the DUT must show.
   // rmode 1 asserts reset mid-cycle, rmode 2 releases it.
   task automatic cycle(input logic rdy, input logic z, input int rmode,
                        input string nm, input outv_t e, input outv_t m);
      @(posedge clk);
      #1;
      opcode    = cur_op;
      funct3    = cur_f3;
      mem_ready = rdy;
      zero      = z;
      if (rmode == 2) reset = 1'b1;
      exp_q.push_back(e);
      mask_q.push_back(m);
      name_q.push_back(nm);
      if (rmode == 1) begin
         #1;
         reset = 1'b0;
      end
   endtask

   task automatic reset_seq();
      cycle(rb(), rb(), 1, "reset_assert", '0, '1);
      cycle(rb(), rb(), 0, "reset_hold", '0, '1);
      cycle(rb(), rb(), 2, "idle", '0, '1);
   endtask

   task automatic halt_seq(input int n, input logic il, input logic to);
      outv_t e;
      e         = '0;
      e.halted  = 1'b1;
      e.illegal = il;
      e.timeout = to;
      for (int i = 0; i < n; i++) begin
         cur_op = 7'($urandom);
         cur_f3 = 3'($urandom);
         cycle(rb(), rb(), 0, "halt", e, bm());
      end
      reset_seq();
   endtask

   // kind: 0 ld, 1 sd, 2 R-type, 3 beq, 4 bne, 5 unsupported (iop/if3).
   task automatic run_instr(input int kind, input logic [6:0] iop, input logic [2:0] if3,
                            input int fwait, input int mwait, input logic zf,
                            input int rst_at, input int nhalt);
      outv_t      e, m;
      logic [1:0] isel;
      logic       taken;
      cur_f3 = 3'($urandom);
      isel   = 2'b00;
      case (kind)
         0: cur_op = 7'b0000011;
         1: begin cur_op = 7'b0100011; isel = 2'b01; end
         2: cur_op = 7'b0110011;
         3: begin cur_op = 7'b1100011; cur_f3 = 3'b000; isel = 2'b11; end
         4: begin cur_op = 7'b1100011; cur_f3 = 3'b001; isel = 2'b11; end
         default: begin cur_op = iop; cur_f3 = if3; end
      endcase
      // fetch: wait cycles, then the transfer
      e = '0; e.mem_req = 1'b1;
      m = bm(); m.mem_we = 1'b1;
      for (int i = 0; i < fwait && i < TO; i++) cycle(1'b0, rb(), 0, "fetch_wait", e, m);
      if (fwait >= TO) begin
         halt_seq(3, 1'b0, 1'b1);
         return;
      end
      e.ir_write = 1'b1; e.pc_write = 1'b1;
      m.pc_src = 1'b1;
      cycle(1'b1, rb(), 0, "fetch_xfer", e, m);
      // decode
      e = '0; m = bm();
      if (kind != 2 && kind < 5) begin e.imm_sel = isel; m.imm_sel = 2'b11; end
      cycle(rb(), rb(), 0, "decode", e, m);
      if (kind == 5) begin
         halt_seq(nhalt, 1'b1, 1'b0);
         return;
      end
      // execute
      e = '0; m = bm(); m.alu_src = 1'b1; m.alu_op = 2'b11;
      if (kind != 2) begin e.imm_sel = isel; m.imm_sel = 2'b11; end
      case (kind)
         0, 1: begin e.alu_src = 1'b1; e.alu_op = 2'b00; end
         2:    e.alu_op = 2'b10;
         default: begin
            e.alu_op = 2'b01;
            taken = (kind == 3) ? zf : !zf;
            if (taken) begin e.pc_write = 1'b1; e.pc_src = 1'b1; m.pc_src = 1'b1; end
         end
      endcase
      cycle(rb(), zf, 0, "exec", e, m);
      if (kind >= 3) return;
      // memory access
      if (kind <= 1) begin
         e = '0; e.mem_req = 1'b1; e.mem_we = (kind == 1); e.imm_sel = isel;
         m = bm(); m.mem_we = 1'b1; m.imm_sel = 2'b11;
         for (int i = 0; i < mwait && i < TO; i++) begin
            if (i == rst_at) begin
               reset_seq();
               return;
            end
            cycle(1'b0, rb(), 0, "mem_wait", e, m);
         end
         if (mwait >= TO) begin
            halt_seq(3, 1'b0, 1'b1);
            return;
         end
         cycle(1'b1, rb(), 0, "mem_xfer", e, m);
         if (kind == 1) return;
      end
      // write-back
      e = '0; e.reg_write = 1'b1; e.mem_to_reg = (kind == 0);
      m = bm(); m.mem_to_reg = 1'b1;
      cycle(rb(), rb(), 0, "wb", e, m);
   endtask

   function automatic int pick_wait();
      int r;
      r = int'($urandom_range(0, 39));
      if (r < 34) return r % 4;
      if (r < 38) return TO - 1;
      return TO;
   endfunction

   // Monitor: compare one queued expectation per cycle, mid-period.
   initial begin
      outv_t act, e, m;
      string nm;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            m  = mask_q.pop_front();
            nm = name_q.pop_front();
            act = {ir_write, pc_write, pc_src, imm_sel, alu_src, alu_op, mem_req,
                   mem_we, reg_write, mem_to_reg, halted, illegal, timeout};
            tests++;
            if (((act ^ e) & m) != '0) begin
               fails++;
               $display("FAIL %s @%0t: got %h expected %h (mask %h)", nm, $time, act, e, m);
            end
         end
      end
   end

   // Stimulus: directed scenarios around a randomized instruction stream.
   initial begin
      logic [6:0] op;
      logic [2:0] f3;
      int         k;
      reset = 1'b0; opcode = '0; funct3 = '0; zero = 1'b0; mem_ready = 1'b0;
      cur_op = '0; cur_f3 = '0;
      for (int i = 0; i < 3; i++) cycle(rb(), rb(), 0, "reset", '0, '1);
      cycle(rb(), rb(), 2, "idle", '0, '1);

      run_instr(2, '0, '0, 0, 0, 1'b0, -1, 0);       // R-type, zero-wait
      run_instr(0, '0, '0, 0, 3, 1'b0, -1, 0);       // ld with three MEM waits
      run_instr(3, '0, '0, 0, 0, 1'b1, -1, 0);       // beq taken
      run_instr(3, '0, '0, 0, 0, 1'b0, -1, 0);       // beq not taken
      run_instr(4, '0, '0, 0, 0, 1'b0, -1, 0);       // bne taken
      run_instr(4, '0, '0, 0, 0, 1'b1, -1, 0);       // bne not taken
      run_instr(1, '0, '0, 0, 0, 1'b0, -1, 0);       // sd
      run_instr(0, '0, '0, TO - 1, TO - 1, 1'b0, -1, 0); // ready on last allowed cycle

      for (int n = 0; n < 300; n++) begin
         k = int'($urandom_range(0, 10));
         if (k < 10) begin
            run_instr(k / 2, '0, '0, pick_wait(), pick_wait(), rb(), -1, 3);
         end else begin
            do begin
               op = 7'($urandom);
               f3 = 3'($urandom);
            end while (is_legal(op, f3));
            run_instr(5, op, f3, pick_wait(), 0, rb(), -1, 3);
         end
      end

      run_instr(2, '0, '0, TO, 0, 1'b0, -1, 0);          // FETCH timeout
      run_instr(0, '0, '0, 0, 5, 1'b0, 2, 0);            // reset mid-MEM
      run_instr(1, '0, '0, 1, TO, 1'b0, -1, 0);          // MEM timeout on store
      run_instr(5, 7'b1111111, 3'b000, 0, 0, 1'b0, -1, 20); // illegal, 20 halted cycles
      run_instr(5, 7'b1100011, 3'b010, 2, 0, 1'b0, -1, 3);  // branch with bad funct3
      run_instr(3, '0, '0, 0, 0, 1'b1, -1, 0);           // recovers after reset

      repeat (3) @(posedge clk);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
